// File: rtl/ifft_block_serializer.sv
// ifft_block_serializer
// Parallel-to-serial output stage at the tail of the 8-point iFFT chain.
// Captures a full real block on an in_en strobe and streams it out one
// normalised sample per beat over valid/ready. Two block slots (ping-pong)
// let the non-stallable upstream deliver a block while the previous drains.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_en      one-cycle strobe, in_data holds a complete block
//   in_data    N samples, sample k at [k*W +: W]
//   out_data   current serial sample, (x + 2^(SHIFT-1)) >>> SHIFT
//   out_valid  out_data is valid
//   out_ready  sink accepts the beat when out_valid && out_ready
//   out_last   marks sample N-1 of each block
//   overflow   sticky, a block arrived while both slots stayed full
//   blk_count  blocks fully emitted, wraps at 2^16
module ifft_block_serializer #(
    parameter int W     = 32,
    parameter int N     = 8,
    parameter int SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [N*W-1:0]   in_data,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow,
    output logic [15:0]      blk_count
);

    localparam logic [2:0] LAST_IDX = 3'(N - 1);
    localparam int         RSH      = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [W:0] ROUND =
        (SHIFT == 0) ? '0 : ((W + 1)'(1) << RSH);

    logic [N*W-1:0] slot0, slot1;
    logic [1:0]     count;
    logic           wr_ptr, rd_ptr;
    logic [2:0]     idx;

    logic           beat, blk_done, accept, drop;
    logic [1:0]     count_n;
    logic [2:0]     idx_n;
    logic           rd_ptr_n;
    logic [N*W-1:0] src_blk;
    logic [W-1:0]   sample_n;

    // Rounded arithmetic right shift; one guard bit keeps x + round exact.
    function automatic logic [W-1:0] norm(input logic [W-1:0] x);
        logic signed [W:0] ext;
        ext = signed'({x[W-1], x}) + ROUND;
        ext = ext >>> SHIFT;
        return ext[W-1:0];
    endfunction

    always_comb begin
        beat     = out_valid && out_ready;
        blk_done = beat && (idx == LAST_IDX);
        // A release on the same edge frees a slot for the incoming block.
        accept   = in_en && ((count != 2'd2) || blk_done);
        drop     = in_en && !accept;

        count_n = count;
        unique case ({accept, blk_done})
            2'b10:   count_n = count + 2'd1;
            2'b01:   count_n = count - 2'd1;
            default: count_n = count;
        endcase

        idx_n = idx;
        if (blk_done) begin
            idx_n = '0;
        end else if (beat) begin
            idx_n = idx + 3'd1;
        end

        rd_ptr_n = rd_ptr ^ blk_done;

        // When the next slot to read is the one being written this edge, the
        // stored copy is not there yet, so present the sample from in_data.
        if (accept && (wr_ptr == rd_ptr_n)) begin
            src_blk = in_data;
        end else begin
            src_blk = rd_ptr_n ? slot1 : slot0;
        end
        sample_n = src_blk[int'(idx_n) * W +: W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0     <= '0;
            slot1     <= '0;
            count     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
            blk_count <= '0;
        end else begin
            if (accept) begin
                if (wr_ptr) begin
                    slot1 <= in_data;
                end else begin
                    slot0 <= in_data;
                end
                wr_ptr <= ~wr_ptr;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (blk_done) begin
                blk_count <= blk_count + 16'd1;
            end
            count     <= count_n;
            rd_ptr    <= rd_ptr_n;
            idx       <= idx_n;
            out_valid <= (count_n != 2'd0);
            out_data  <= (count_n != 2'd0) ? norm(sample_n) : '0;
            out_last  <= (count_n != 2'd0) && (idx_n == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_ifft_block_serializer.sv
// Scoreboard bench for ifft_block_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_ifft_block_serializer;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_en;
    logic [N*W-1:0] in_data;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           overflow;
    logic [15:0]    blk_count;

    typedef struct packed {
        logic [W-1:0] d;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   beats  = 0;

    ifft_block_serializer #(.W(W), .N(N), .SHIFT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            beats++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h with no beat expected", out_data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", out_data, e.d);
                check("beat_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d[N], input logic [W-1:0] e[N], input bit acc);
        in_en = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_data[k*W +: W] = d[k];
            if (acc) exp_q.push_back('{d: e[k], last: (k == N - 1)});
        end
    endtask

    task automatic send(input logic [W-1:0] d[N], input logic [W-1:0] e[N], input bit acc);
        load(d, e, acc);
        tick();
        in_en = 1'b0;
    endtask

    // Block of 8*(base+k), which normalises exactly to base+k.
    task automatic seq_block(input int base, output logic [W-1:0] d[N], output logic [W-1:0] e[N]);
        for (int k = 0; k < N; k++) begin
            d[k] = 32'(8 * (base + k));
            e[k] = 32'(base + k);
        end
    endtask

    task automatic send_seq(input int base, input bit acc);
        logic [W-1:0] d[N];
        logic [W-1:0] e[N];
        seq_block(base, d, e);
        send(d, e, acc);
    endtask

    task automatic drain(output int bubbles);
        bit seen = 0;
        bubbles = 0;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && out_valid == 1'b0) return;
            if (out_valid) seen = 1;
            else if (seen) bubbles++;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d beats still expected after 200 cycles", exp_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] d[N];
        logic [W-1:0] e[N];
        int b0, bub, injected;

        rst = 1'b1; in_en = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_blk_count", 32'(blk_count), 32'd0);
        rst = 1'b0;
        tick();
        out_ready = 1'b1;

        // single block, latency and count
        d = '{32'd8, 32'd16, 32'd24, 32'd32, 32'd40, 32'd48, 32'd56, 32'd64};
        e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check("idle_valid", 32'(out_valid), 32'd0);
        b0 = beats;
        send(d, e, 1);
        check("latency_valid", 32'(out_valid), 32'd1);
        drain(bub);
        check("t1_beats", 32'(beats - b0), 32'd8);
        check("t1_blk_count", 32'(blk_count), 32'd1);
        check("t1_valid_low", 32'(out_valid), 32'd0);

        // rounding
        d = '{32'hFFFF_FFF4, 32'hFFFF_FFF3, 32'd11, 32'd12,
              32'h7FFF_FFFF, 32'h8000_0000, 32'd4, 32'hFFFF_FFFC};
        e = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 32'd2,
              32'h1000_0000, 32'hF000_0000, 32'd1, 32'd0};
        send(d, e, 1);
        drain(bub);
        check("t2_blk_count", 32'(blk_count), 32'd2);

        // two blocks back to back, gapless
        b0 = beats;
        send_seq(1, 1);
        send_seq(9, 1);
        drain(bub);
        check("t3_bubbles", 32'(bub), 32'd0);
        check("t3_beats", 32'(beats - b0), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd0);
        check("t3_blk_count", 32'(blk_count), 32'd4);

        // backpressure, third block dropped
        out_ready = 1'b0;
        b0 = beats;
        send_seq(17, 1);
        send_seq(25, 1);
        send_seq(33, 0);
        check("t4_overflow_set", 32'(overflow), 32'd1);
        tick(); tick(); tick();
        check("t4_hold_valid", 32'(out_valid), 32'd1);
        check("t4_hold_data", out_data, 32'd17);
        check("t4_hold_last", 32'(out_last), 32'd0);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        drain(bub);
        check("t4_beats", 32'(beats - b0), 32'd16);
        check("t4_overflow_after", 32'(overflow), 32'd1);
        check("t4_blk_count", 32'(blk_count), 32'd6);

        // async reset mid-block
        b0 = beats;
        send_seq(41, 1);
        for (int c = 0; c < 50; c++) begin
            if (beats - b0 >= 4) break;
            tick();
        end
        check("t6_beats_before_rst", 32'(beats - b0), 32'd4);
        rst = 1'b1;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_data", out_data, 32'd0);
        check("t6_async_last", 32'(out_last), 32'd0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t6_blk_count", 32'(blk_count), 32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        send_seq(49, 1);
        drain(bub);
        check("t6_blk_after", 32'(blk_count), 32'd1);

        // full buffer, toggling ready, accept on last-beat edge
        out_ready = 1'b0;
        b0 = beats;
        send_seq(57, 1);
        send_seq(65, 1);
        injected = 0;
        seq_block(73, d, e);
        for (int c = 0; c < 200; c++) begin
            out_ready = (c % 2 == 0);
            if (injected == 0 && out_ready && out_last) begin
                load(d, e, 1);
                injected = 1;
            end
            tick();
            in_en = 1'b0;
            if (exp_q.size() == 0 && out_valid == 1'b0) break;
        end
        check("t5_injected", 32'(injected), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd0);
        check("t5_beats", 32'(beats - b0), 32'd24);
        check("t5_blk_count", 32'(blk_count), 32'd4);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifft_block_serializer.md
Name: ifft_block_serializer

Overview:
- Parallel-to-serial output stage at the tail of the 8-point FFT/iFFT chain.
- Captures one 8-sample real block from the last iFFT stage (the eight ifft_3 real outputs plus the stage enable) and streams it out one sample per beat over a valid/ready interface.
- Applies the 1/N iFFT normalisation as a rounded arithmetic shift.
- Holds two blocks (ping-pong) so the upstream pipeline, which has no backpressure, can deliver a new block while the previous one drains.

Parameters:
- W, 32, sample width in bits (signed, two's complement)
- N, 8, samples per block (fixed at 8; index counter is 3 bits)
- SHIFT, 3, normalisation right-shift; 0 = pass-through

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_en  in  1  one-cycle strobe; in_data holds a complete block this cycle
- in_data  in  N*W  block; sample k at bits [k*W +: W], k=0 is ifft_3_re[0]
- out_data  out  W  current serial sample (normalised)
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the beat when out_valid && out_ready
- out_last  out  1  high with sample index N-1 of each block
- overflow  out  1  sticky; a block arrived while both slots were full
- blk_count  out  16  blocks fully emitted, wraps at 2^16

Behaviour:
- Reset (asynchronous assert): all outputs go to 0, both slots are marked empty, read/write pointers and sample index are 0, and overflow is cleared. Reset deassertion takes effect on the next clk edge. Reset mid-block discards everything, including any partially emitted block; no out_last is produced for it.
- Storage and pointers:
  - Two slots of N*W bits each, plus a 2-bit occupancy count (0..2).
  - 1-bit wr_ptr and rd_ptr; 3-bit idx for the sample currently presented.
- Accept:
  - On a clk edge with in_en=1 and count<2 (evaluated after this cycle's release, see below), in_data is written into slot[wr_ptr], wr_ptr toggles and count increments.
  - If the slots remain full after the release, the block is dropped, overflow sets to 1 and holds until reset, and no state changes.
- Emit:
  - While count>0: out_valid=1, out_data=norm(slot[rd_ptr][idx]), out_last=(idx==N-1).
  - A beat is taken on out_valid&&out_ready. idx increments; when the beat has idx==N-1, idx goes to 0, rd_ptr toggles, count decrements and blk_count increments.
  - out_valid, out_data and out_last are registered. When count goes 0->1, out_valid rises the cycle after the accepting edge (latency 1).
  - Blocks are back-to-back with no bubble: the beat after out_last carries sample 0 of the next slot if count>0 after the release.
- Simultaneous events:
  - With count==2, a last-beat release and in_en on the same edge accept the block; count stays 2.
  - With count==0, in_en and empty output are handled normally.
  - Accept and release on the same edge with count==1 leaves count at 1.
- out_ready=0 holds out_data, out_last and idx stable. out_valid never drops while count>0.
- Normalisation:
  - norm(x) = (x + 2^(SHIFT-1)) >>> SHIFT, computed in W+1 bits and truncated to W. This is exact, with no overflow possible for SHIFT>=1.
  - Rounding is half toward +infinity: -12 with SHIFT=3 gives -1; -13 gives -2; 12 gives 2; 11 gives 1.
  - SHIFT=0 outputs x unchanged.
- No state machine beyond the count/idx control above. The design is fully synchronous apart from the async reset. There are no combinational paths from in_en to the outputs.

Test Plan:
- Reset, then one block {8,16,24,32,40,48,56,64} with out_ready=1 -> out_valid rises 1 cycle after in_en; data 1..8 on 8 consecutive beats; out_last only on 8; blk_count=1; out_valid then 0.
- Rounding block {-12,-13,11,12,0x7FFFFFFF,0x80000000,4,-4} with SHIFT=3 -> -1,-2,1,2,0x10000000,0xF0000000,1,0.
- Two blocks on consecutive cycles, out_ready=1 -> 16 gapless beats; out_last on beats 8 and 16; overflow=0.
- out_ready=0 while three blocks are strobed -> first two stored, third dropped, overflow=1 and sticky. Then out_ready=1 -> exactly 16 beats from blocks 1 and 2.
- Full buffer, out_ready toggling; in_en on the same edge as a last-beat handshake -> block accepted; overflow stays 0; 24 beats total in order.
- rst pulsed at beat 4 of a block -> out_valid=0 immediately (async); the next block emits from sample 0; blk_count=0; overflow=0.
